// File: rtl/text_writer_if.sv
// Handshake and character-RAM write bus between the terminal input path,
// the text writer and the character RAM.
interface text_writer_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
);
    logic [6:0]             in_ascii;
    logic                   in_valid;
    logic                   in_ready;
    logic                   wr_en;
    logic [ROW_W+COL_W-1:0] wr_addr;
    logic [6:0]             wr_data;
    logic [ROW_W-1:0]       cursor_row;
    logic [COL_W-1:0]       cursor_col;

    modport master (
        output in_ascii, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, cursor_row, cursor_col
    );

    modport slave (
        input  in_ascii, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, cursor_row, cursor_col
    );
endinterface

// File: rtl/text_writer.sv
// Character-cell writer: consumes ASCII bytes, tracks the cursor and issues
// registered writes (including row/screen clear sweeps) to the character RAM.
//
// state   | meaning
// CLR_ALL | sweeping 0x20 into every cell, counter = cell address
// IDLE    | accepting bytes, one per cycle
// CLR_ROW | sweeping 0x20 into the cursor row, counter = column
module text_writer #(
    parameter int COLS  = 16,
    parameter int ROWS  = 16,
    parameter int COL_W = 4,
    parameter int ROW_W = 4
) (
    input logic         clk,
    input logic         rst,
    text_writer_if.slave tw
);
    localparam int AW    = ROW_W + COL_W;
    localparam int CELLS = ROWS * COLS;

    localparam logic [6:0] ASC_SP  = 7'h20;
    localparam logic [6:0] ASC_DEL = 7'h7F;
    localparam logic [6:0] ASC_BS  = 7'h08;
    localparam logic [6:0] ASC_LF  = 7'h0A;
    localparam logic [6:0] ASC_FF  = 7'h0C;
    localparam logic [6:0] ASC_CR  = 7'h0D;

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    cnt, cnt_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic             wr_en_q, wr_en_nxt;
    logic [AW-1:0]    wr_addr_q, wr_addr_nxt;
    logic [6:0]       wr_data_q, wr_data_nxt;
    logic             accept;
    logic             printable;

    assign accept    = tw.in_valid && (state == IDLE);
    assign printable = (tw.in_ascii >= ASC_SP) && (tw.in_ascii != ASC_DEL);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        row_nxt     = row;
        col_nxt     = col;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr_q;
        wr_data_nxt = wr_data_q;
        case (state)
            CLR_ALL: begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = cnt;
                wr_data_nxt = ASC_SP;
                cnt_nxt     = cnt + 1'b1;
                if (cnt == AW'(CELLS - 1)) begin
                    state_nxt = IDLE;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
            end
            CLR_ROW: begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = {row, cnt[COL_W-1:0]};
                wr_data_nxt = ASC_SP;
                cnt_nxt     = cnt + 1'b1;
                if (cnt[COL_W-1:0] == COL_W'(COLS - 1))
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = {row, col};
                        wr_data_nxt = tw.in_ascii;
                        if (col != COL_W'(COLS - 1)) begin
                            col_nxt = col + 1'b1;
                        end else begin
                            // Wrapping onto a new line clears it; no scrolling.
                            col_nxt   = '0;
                            row_nxt   = row + 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = CLR_ROW;
                        end
                    end else begin
                        case (tw.in_ascii)
                            ASC_LF: begin
                                col_nxt   = '0;
                                row_nxt   = row + 1'b1;
                                cnt_nxt   = '0;
                                state_nxt = CLR_ROW;
                            end
                            ASC_CR: col_nxt = '0;
                            ASC_BS: begin
                                if (col != '0) begin
                                    col_nxt     = col - 1'b1;
                                    wr_en_nxt   = 1'b1;
                                    wr_addr_nxt = {row, col - 1'b1};
                                    wr_data_nxt = ASC_SP;
                                end
                            end
                            ASC_FF: begin
                                row_nxt   = '0;
                                col_nxt   = '0;
                                cnt_nxt   = '0;
                                state_nxt = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: begin
                state_nxt = CLR_ALL;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLR_ALL;
            cnt       <= '0;
            row       <= '0;
            col       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            row       <= row_nxt;
            col       <= col_nxt;
            wr_en_q   <= wr_en_nxt;
            wr_addr_q <= wr_addr_nxt;
            wr_data_q <= wr_data_nxt;
        end
    end

    assign tw.in_ready   = (state == IDLE);
    assign tw.wr_en      = wr_en_q;
    assign tw.wr_addr    = wr_addr_q;
    assign tw.wr_data    = wr_data_q;
    assign tw.cursor_row = row;
    assign tw.cursor_col = col;
endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer: vector table for single-byte
// effects plus hand-written sequences for sweeps, wraps and reset.
module tb_text_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    text_writer_if #(.ROW_W(4), .COL_W(4)) tw ();

    text_writer #(.COLS(16), .ROWS(16), .COL_W(4), .ROW_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .tw  (tw)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [6:0] ascii;
        logic       exp_en;
        logic [7:0] exp_addr;
        logic [6:0] exp_data;
        logic [3:0] exp_row;
        logic [3:0] exp_col;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [6:0] c);
        int n = 0;
        tw.in_ascii = c;
        tw.in_valid = 1'b1;
        while (!tw.in_ready && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 32'(tw.in_ready), 32'd1);
        @(posedge clk); #1;
        tw.in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wr_en"},   32'(tw.wr_en),      32'd0);
        chk({tag, "_wr_addr"}, 32'(tw.wr_addr),    32'd0);
        chk({tag, "_wr_data"}, 32'(tw.wr_data),    32'd0);
        chk({tag, "_ready"},   32'(tw.in_ready),   32'd0);
        chk({tag, "_row"},     32'(tw.cursor_row), 32'd0);
        chk({tag, "_col"},     32'(tw.cursor_col), 32'd0);
    endtask

    task automatic check_full_sweep();
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            chk("sweep_en",    32'(tw.wr_en),    32'd1);
            chk("sweep_addr",  32'(tw.wr_addr),  32'(i));
            chk("sweep_data",  32'(tw.wr_data),  32'h20);
            chk("sweep_ready", 32'(tw.in_ready), 32'(i == 255));
        end
        chk("sweep_row", 32'(tw.cursor_row), 32'd0);
        chk("sweep_col", 32'(tw.cursor_col), 32'd0);
    endtask

    task automatic check_row_clear(input int r);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            chk("rowclr_en",    32'(tw.wr_en),    32'd1);
            chk("rowclr_addr",  32'(tw.wr_addr),  32'(r * 16 + k));
            chk("rowclr_data",  32'(tw.wr_data),  32'h20);
            chk("rowclr_ready", 32'(tw.in_ready), 32'(k == 15));
        end
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        chk({name, "_row"}, 32'(tw.cursor_row), 32'(r));
        chk({name, "_col"}, 32'(tw.cursor_col), 32'(c));
    endtask

    task automatic check_write(input string name, input int a, input int d);
        chk({name, "_en"},   32'(tw.wr_en),   32'd1);
        chk({name, "_addr"}, 32'(tw.wr_addr), 32'(a));
        chk({name, "_data"}, 32'(tw.wr_data), 32'(d));
    endtask

    task automatic line_feed_and_settle();
        send_byte(7'h0A);
        repeat (16) @(posedge clk);
        #1;
    endtask

    initial begin
        // cursor starts at (0,0) after the power-up sweep
        vecs[0] = '{7'h41, 1'b1, 8'h00, 7'h41, 4'd0, 4'd1};  // 'A'
        vecs[1] = '{7'h42, 1'b1, 8'h01, 7'h42, 4'd0, 4'd2};  // 'B'
        vecs[2] = '{7'h0D, 1'b0, 8'h00, 7'h00, 4'd0, 4'd0};  // CR
        vecs[3] = '{7'h01, 1'b0, 8'h00, 7'h00, 4'd0, 4'd0};  // unknown control
        vecs[4] = '{7'h08, 1'b0, 8'h00, 7'h00, 4'd0, 4'd0};  // BS at col 0
        vecs[5] = '{7'h51, 1'b1, 8'h00, 7'h51, 4'd0, 4'd1};  // 'Q'
        vecs[6] = '{7'h08, 1'b1, 8'h00, 7'h20, 4'd0, 4'd0};  // BS erases 'Q'
        vecs[7] = '{7'h7F, 1'b0, 8'h00, 7'h00, 4'd0, 4'd0};  // DEL is not printable
        vecs[8] = '{7'h43, 1'b1, 8'h00, 7'h43, 4'd0, 4'd1};  // 'C'

        tw.in_ascii = 7'h00;
        tw.in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        tw.in_valid = 1'b1;
        tw.in_ascii = 7'h41;
        @(negedge clk);
        rst = 1'b0;
        check_full_sweep();
        tw.in_valid = 1'b0;

        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].ascii);
            chk("vec_en", 32'(tw.wr_en), 32'(vecs[i].exp_en));
            if (vecs[i].exp_en) begin
                chk("vec_addr", 32'(tw.wr_addr), 32'(vecs[i].exp_addr));
                chk("vec_data", 32'(tw.wr_data), 32'(vecs[i].exp_data));
            end
            check_cursor("vec", int'(vecs[i].exp_row), int'(vecs[i].exp_col));
            chk("vec_ready", 32'(tw.in_ready), 32'd1);
        end

        // printable at the last column wraps and clears the next row
        send_byte(7'h0D);
        for (int i = 0; i < 15; i++) send_byte(7'h78);
        check_cursor("pre_wrap", 0, 15);
        send_byte(7'h5A);
        check_write("wrap_char", 8'h0F, 7'h5A);
        chk("wrap_ready", 32'(tw.in_ready), 32'd0);
        check_cursor("wrap", 1, 0);
        check_row_clear(1);
        @(posedge clk); #1;
        chk("wrap_idle_en", 32'(tw.wr_en), 32'd0);

        // LF from the last row wraps to row 0
        for (int i = 0; i < 14; i++) line_feed_and_settle();
        check_cursor("lf14", 15, 0);
        for (int i = 0; i < 3; i++) send_byte(7'h79);
        check_cursor("pre_lf", 15, 3);
        send_byte(7'h0A);
        chk("lf_en", 32'(tw.wr_en), 32'd0);
        chk("lf_ready", 32'(tw.in_ready), 32'd0);
        check_cursor("lf", 0, 0);
        check_row_clear(0);
        send_byte(7'h08);
        chk("bs0_en", 32'(tw.wr_en), 32'd0);
        check_cursor("bs0", 0, 0);
        send_byte(7'h51);
        check_write("q", 8'h00, 7'h51);
        send_byte(7'h08);
        check_write("bs", 8'h00, 7'h20);
        check_cursor("bs", 0, 0);

        // CR and an unknown control code
        for (int i = 0; i < 5; i++) line_feed_and_settle();
        for (int i = 0; i < 7; i++) send_byte(7'h79);
        check_cursor("pre_cr", 5, 7);
        send_byte(7'h0D);
        chk("cr_en", 32'(tw.wr_en), 32'd0);
        check_cursor("cr", 5, 0);
        send_byte(7'h01);
        chk("ctl_en", 32'(tw.wr_en), 32'd0);
        chk("ctl_ready", 32'(tw.in_ready), 32'd1);
        check_cursor("ctl", 5, 0);

        // FF, then reset in the middle of its sweep
        send_byte(7'h0C);
        chk("ff_en", 32'(tw.wr_en), 32'd0);
        chk("ff_ready", 32'(tw.in_ready), 32'd0);
        check_cursor("ff", 0, 0);
        repeat (99) @(posedge clk);
        #1;
        chk("ff_mid_addr", 32'(tw.wr_addr), 32'd98);
        chk("ff_mid_en", 32'(tw.wr_en), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_full_sweep();
        send_byte(7'h41);
        check_write("post_rst", 8'h00, 7'h41);
        check_cursor("post_rst", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
